cohort_impl: RTL and testbench
==============================

COHORT_IMPL -- requirements
Module: cohort_impl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of load-request queue entries (power of two, at least 2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, meaning the maximum number of issued loads still awaiting a response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port conf_valid, input, 1 bit: a configuration write is presented.
REQ-006 SHALL have port conf_ready, output, 1 bit: the configuration write is accepted this cycle.
REQ-007 SHALL have port conf_addr, input, 3 bits: register index.
REQ-008 SHALL have port conf_data, input, 32 bits: write data.
REQ-009 SHALL have port conf_tag, input, 4 bits: request tag forwarded with triggered loads.
REQ-010 SHALL have port load_req_valid, output, 1 bit: a load request is presented.
REQ-011 SHALL have port load_req_ready, input, 1 bit: the memory side accepts the request.
REQ-012 SHALL have port load_req_addr, output, 32 bits: load address.
REQ-013 SHALL have port load_req_tag, output, 4 bits: load tag.
REQ-014 SHALL have port atomic_resp_valid, input, 1 bit: a response is present; it is always accepted, with no ready.
REQ-015 SHALL have port atomic_resp_tag, input, 4 bits: response tag.
REQ-016 SHALL have port atomic_resp_data, input, 64 bits: response data.
REQ-017 SHALL have outputs outstanding (5 bits), last_resp_data (64 bits), last_resp_tag (4 bits), err (1 bit) and busy (1 bit).

Function
REQ-018 SHALL complete a config write on a rising edge where conf_valid and conf_ready are both high.
REQ-019 SHALL define the register map as: index 0 = CTRL (bit0 is the enable), index 1 to 6 = scratch registers with no side effect, index 7 = LOAD_TRIGGER.
REQ-020 SHALL, on a completed write to index 7, push {addr = conf_data, tag = conf_tag} into the request FIFO.
REQ-021 SHALL drive conf_ready low only when the FIFO is full, and otherwise high; writes to indices 0 to 6 are subject to the same rule.
REQ-022 SHALL drive load_req_valid = FIFO not empty AND CTRL.enable AND (outstanding < MAX_OUTSTANDING).
REQ-023 SHALL drive load_req_addr and load_req_tag from the FIFO head.
REQ-024 SHALL pop the FIFO head on a rising edge where load_req_valid and load_req_ready are both high.
REQ-025 SHALL hold load_req_valid, load_req_addr and load_req_tag stable while load_req_valid is high and load_req_ready is low.
REQ-026 SHALL give a latency of one cycle: a trigger write completing at edge N into an empty FIFO makes load_req_valid high after edge N.
REQ-027 SHALL issue requests in FIFO order, with no reordering or merging.
REQ-028 SHALL support a push and a pop on the same edge: occupancy is unchanged, and a push to a full FIFO cannot occur because conf_ready is low.
REQ-029 SHALL update outstanding as +1 on a load handshake, -1 on atomic_resp_valid, and unchanged when both happen on the same edge.
REQ-030 SHALL, on atomic_resp_valid while outstanding == 0 with no same-edge handshake, leave outstanding at 0 and set err, which is sticky.
REQ-031 SHALL, on atomic_resp_valid, register atomic_resp_data and atomic_resp_tag into last_resp_data and last_resp_tag; the response tag is not checked against issued tags.
REQ-032 SHALL, when CTRL.enable is 0, keep load_req_valid low, retain queued entries and keep accepting writes.
REQ-033 SHALL drive busy = FIFO not empty OR outstanding != 0.

Reset
REQ-034 SHALL, on rst_n low, immediately and asynchronously clear the FIFO (empty) and set load_req_valid = 0, outstanding = 0, err = 0, last_resp_data = 0, last_resp_tag = 0, CTRL.enable = 1, scratch registers = 0 and busy = 0.
REQ-035 SHALL drive conf_ready high during and after reset.
REQ-036 SHALL, on reset asserted mid-transfer, drop queued and in-flight requests without issuing them.
REQ-037 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-038 SHALL be verified by: after reset, config write (data 0xDEADBEEF, addr 7, tag 0x4) with load_req_ready high -> one cycle later load_req_valid = 1, load_req_addr = 0xDEADBEEF, load_req_tag = 0x4; after the handshake outstanding = 1.
REQ-039 SHALL be verified by: load_req_ready low, 5 trigger writes -> the 5th stalls with conf_ready = 0; raise load_req_ready -> addresses emerge in write order and the 5th write then completes.
REQ-040 SHALL be verified by: write CTRL = 0, then trigger 0x1000 -> load_req_valid stays 0; write CTRL = 1 -> request 0x1000 issues.
REQ-041 SHALL be verified by: issue 16 loads -> the 17th is held with valid = 0; one atomic_resp (tag 3, data 0x0123456789ABCDEF) -> last_resp_data and last_resp_tag update, and the 17th issues.
REQ-042 SHALL be verified by: atomic_resp_valid with outstanding = 0 -> err = 1 and outstanding stays 0; err persists until reset.
REQ-043 SHALL be verified by: asserting rst_n low while 3 entries are queued -> load_req_valid drops immediately, busy = 0 and outstanding = 0.

Source files
------------

// File: rtl/cohort_impl.sv
// Configuration-triggered load issuer: trigger writes queue load requests that are
// issued in order under an enable and an outstanding-load limit; responses are tracked.
module cohort_impl #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        conf_valid,
    output logic        conf_ready,
    input  logic [2:0]  conf_addr,
    input  logic [31:0] conf_data,
    input  logic [3:0]  conf_tag,
    output logic        load_req_valid,
    input  logic        load_req_ready,
    output logic [31:0] load_req_addr,
    output logic [3:0]  load_req_tag,
    input  logic        atomic_resp_valid,
    input  logic [3:0]  atomic_resp_tag,
    input  logic [63:0] atomic_resp_data,
    output logic [4:0]  outstanding,
    output logic [63:0] last_resp_data,
    output logic [3:0]  last_resp_tag,
    output logic        err,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       OUT_LIMIT  = 5'(MAX_OUTSTANDING);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_TRIGGER = 3'd7;

    logic [31:0]      r_fifoAddr [FIFO_DEPTH];
    logic [3:0]       r_fifoTag  [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             r_enable;
    logic [4:0]       r_outstanding;
    logic             r_err;
    logic [63:0]      r_lastData;
    logic [3:0]       r_lastTag;

    logic w_empty;
    logic w_full;
    logic w_confFire;
    logic w_push;
    logic w_pop;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_confFire = conf_valid && conf_ready;
    assign w_push     = w_confFire && (conf_addr == ADDR_TRIGGER);
    assign w_pop      = load_req_valid && load_req_ready;

    assign conf_ready     = !w_full;
    assign load_req_valid = !w_empty && r_enable && (r_outstanding < OUT_LIMIT);
    assign load_req_addr  = r_fifoAddr[r_rdPtr];
    assign load_req_tag   = r_fifoTag[r_rdPtr];
    assign outstanding    = r_outstanding;
    assign last_resp_data = r_lastData;
    assign last_resp_tag  = r_lastTag;
    assign err            = r_err;
    assign busy           = !w_empty || (r_outstanding != 5'd0);

    // Queue storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr] <= conf_data;
            r_fifoTag[r_wrPtr]  <= conf_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Indices 1-6 are scratch with no side effect and no readback path, so only CTRL.enable is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b1;
        end else if (w_confFire && (conf_addr == ADDR_CTRL)) begin
            r_enable <= conf_data[0];
        end
    end

    // A response with nothing in flight (and no same-edge issue) is an underflow: flag it, stay at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 5'd0;
            r_err         <= 1'b0;
        end else begin
            case ({w_pop, atomic_resp_valid})
                2'b10: r_outstanding <= r_outstanding + 5'd1;
                2'b01: begin
                    if (r_outstanding == 5'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_outstanding <= r_outstanding - 5'd1;
                    end
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastData <= 64'd0;
            r_lastTag  <= 4'd0;
        end else if (atomic_resp_valid) begin
            r_lastData <= atomic_resp_data;
            r_lastTag  <= atomic_resp_tag;
        end
    end

endmodule

// File: tb/tb_cohort_impl.sv
// Self-checking bench for cohort_impl: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the load issuer.
module tb_cohort_impl;

    localparam int FIFO_DEPTH      = 4;
    localparam int MAX_OUTSTANDING = 16;

    logic        clk;
    logic        rst_n;
    logic        conf_valid;
    logic        conf_ready;
    logic [2:0]  conf_addr;
    logic [31:0] conf_data;
    logic [3:0]  conf_tag;
    logic        load_req_valid;
    logic        load_req_ready;
    logic [31:0] load_req_addr;
    logic [3:0]  load_req_tag;
    logic        atomic_resp_valid;
    logic [3:0]  atomic_resp_tag;
    logic [63:0] atomic_resp_data;
    logic [4:0]  outstanding;
    logic [63:0] last_resp_data;
    logic [3:0]  last_resp_tag;
    logic        err;
    logic        busy;

    cohort_impl #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .conf_valid        (conf_valid),
        .conf_ready        (conf_ready),
        .conf_addr         (conf_addr),
        .conf_data         (conf_data),
        .conf_tag          (conf_tag),
        .load_req_valid    (load_req_valid),
        .load_req_ready    (load_req_ready),
        .load_req_addr     (load_req_addr),
        .load_req_tag      (load_req_tag),
        .atomic_resp_valid (atomic_resp_valid),
        .atomic_resp_tag   (atomic_resp_tag),
        .atomic_resp_data  (atomic_resp_data),
        .outstanding       (outstanding),
        .last_resp_data    (last_resp_data),
        .last_resp_tag     (last_resp_tag),
        .err               (err),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: the queue holds {tag, addr} in issue order.
    logic [35:0] mQueue [$];
    int          mOuts;
    bit          mErr;
    bit          mEn;
    logic [63:0] mLastData;
    logic [3:0]  mLastTag;
    bit          mAccepted;
    logic [31:0] issued [$];

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic bit modelReady();
        return mQueue.size() < FIFO_DEPTH;
    endfunction

    function automatic bit modelValid();
        return (mQueue.size() > 0) && mEn && (mOuts < MAX_OUTSTANDING);
    endfunction

    task automatic modelReset();
        mQueue.delete();
        mOuts     = 0;
        mErr      = 1'b0;
        mEn       = 1'b1;
        mLastData = '0;
        mLastTag  = '0;
    endtask

    // One clock: check outputs against the model, let the edge happen, advance the model.
    task automatic applyStimulus();
        bit push;
        bit issue;
        bit resp;
        #1;
        checkOutput("conf_ready", conf_ready, modelReady());
        checkOutput("load_req_valid", load_req_valid, modelValid());
        checkOutput("outstanding", outstanding, 64'(mOuts));
        checkOutput("err", err, mErr);
        checkOutput("busy", busy, (mQueue.size() != 0) || (mOuts != 0));
        checkOutput("last_resp_data", last_resp_data, mLastData);
        checkOutput("last_resp_tag", last_resp_tag, mLastTag);
        if (modelValid()) begin
            checkOutput("load_req_addr", load_req_addr, mQueue[0][31:0]);
            checkOutput("load_req_tag", load_req_tag, mQueue[0][35:32]);
        end
        mAccepted = conf_valid && modelReady();
        push      = mAccepted && (conf_addr == 3'd7);
        issue     = modelValid() && load_req_ready;
        resp      = atomic_resp_valid;
        if (load_req_valid && load_req_ready) begin
            issued.push_back(load_req_addr);
        end
        @(posedge clk);
        if (issue) begin
            void'(mQueue.pop_front());
        end
        if (push) begin
            mQueue.push_back({conf_tag, conf_data});
        end
        if (mAccepted && conf_addr == 3'd0) begin
            mEn = conf_data[0];
        end
        if (issue && !resp) begin
            mOuts++;
        end else if (resp && !issue) begin
            if (mOuts == 0) mErr = 1'b1;
            else mOuts--;
        end
        if (resp) begin
            mLastData = atomic_resp_data;
            mLastTag  = atomic_resp_tag;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", load_req_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_outstanding", outstanding, 5'd0);
        checkOutput("rst_conf_ready", conf_ready, 1'b1);
        checkOutput("rst_err", err, 1'b0);
        modelReset();
        conf_valid        = 1'b0;
        atomic_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic confWrite(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] tag);
        conf_valid = 1'b1;
        conf_addr  = addr;
        conf_data  = data;
        conf_tag   = tag;
        applyStimulus();
        conf_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n             = 1'b1;
        conf_valid        = 1'b0;
        conf_addr         = '0;
        conf_data         = '0;
        conf_tag          = '0;
        load_req_ready    = 1'b0;
        atomic_resp_valid = 1'b0;
        atomic_resp_tag   = '0;
        atomic_resp_data  = '0;
        modelReset();
        @(negedge clk);
        doReset();
        applyStimulus();

        $display("[TB] single trigger write");
        load_req_ready = 1'b1;
        confWrite(3'd7, 32'hDEADBEEF, 4'h4);
        load_req_ready = 1'b0;
        checkOutput("first_valid", load_req_valid, 1'b1);
        checkOutput("first_addr", load_req_addr, 32'hDEADBEEF);
        checkOutput("first_tag", load_req_tag, 4'h4);
        load_req_ready = 1'b1;
        applyStimulus();
        load_req_ready = 1'b0;
        checkOutput("first_outstanding", outstanding, 5'd1);

        $display("[TB] FIFO full back-pressure");
        issued.delete();
        for (int i = 0; i < 4; i++) begin
            confWrite(3'd7, 32'h100 + 32'(i), 4'(i));
        end
        checkOutput("full_conf_ready", conf_ready, 1'b0);
        conf_valid = 1'b1;
        conf_data  = 32'h104;
        conf_tag   = 4'h4;
        repeat (2) applyStimulus();
        load_req_ready = 1'b1;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!mAccepted && n < 20);
        conf_valid = 1'b0;
        checkOutput("fifth_write_done", mAccepted, 1'b1);
        n = 0;
        while (issued.size() < 5 && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("issue_count", 64'(issued.size()), 64'd5);
        for (int i = 0; i < 5 && i < issued.size(); i++) begin
            checkOutput("issue_order", issued[i], 32'h100 + 32'(i));
        end
        load_req_ready    = 1'b0;
        atomic_resp_valid = 1'b1;
        repeat (6) applyStimulus();
        atomic_resp_valid = 1'b0;
        checkOutput("drained_outstanding", outstanding, 5'd0);

        $display("[TB] enable gating");
        load_req_ready = 1'b1;
        confWrite(3'd0, 32'd0, 4'd0);
        confWrite(3'd7, 32'h1000, 4'h2);
        repeat (3) applyStimulus();
        checkOutput("disabled_valid", load_req_valid, 1'b0);
        checkOutput("disabled_busy", busy, 1'b1);
        load_req_ready = 1'b0;
        confWrite(3'd0, 32'd1, 4'd0);
        checkOutput("enabled_valid", load_req_valid, 1'b1);
        checkOutput("enabled_addr", load_req_addr, 32'h1000);
        load_req_ready = 1'b1;
        applyStimulus();

        $display("[TB] outstanding limit");
        doReset();
        load_req_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            confWrite(3'd7, 32'h2000 + 32'(i), 4'(i));
        end
        repeat (2) applyStimulus();
        checkOutput("limit_outstanding", outstanding, 5'd16);
        checkOutput("limit_valid", load_req_valid, 1'b0);
        atomic_resp_valid = 1'b1;
        atomic_resp_tag   = 4'h3;
        atomic_resp_data  = 64'h0123456789ABCDEF;
        load_req_ready    = 1'b0;
        applyStimulus();
        atomic_resp_valid = 1'b0;
        checkOutput("resp_data", last_resp_data, 64'h0123456789ABCDEF);
        checkOutput("resp_tag", last_resp_tag, 4'h3);
        checkOutput("seventeenth_valid", load_req_valid, 1'b1);
        checkOutput("seventeenth_addr", load_req_addr, 32'h2010);
        load_req_ready = 1'b1;
        applyStimulus();
        checkOutput("refilled_outstanding", outstanding, 5'd16);

        $display("[TB] response underflow");
        doReset();
        atomic_resp_valid = 1'b1;
        atomic_resp_data  = 64'h55;
        applyStimulus();
        atomic_resp_valid = 1'b0;
        checkOutput("underflow_err", err, 1'b1);
        checkOutput("underflow_outstanding", outstanding, 5'd0);
        repeat (3) applyStimulus();
        checkOutput("sticky_err", err, 1'b1);

        $display("[TB] reset with queued entries");
        doReset();
        load_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            confWrite(3'd7, 32'h3000 + 32'(i), 4'(i));
        end
        checkOutput("queued_valid", load_req_valid, 1'b1);
        checkOutput("queued_busy", busy, 1'b1);
        doReset();
        applyStimulus();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel        = int'($urandom_range(0, 9));
            conf_valid = ($urandom_range(0, 1) == 1);
            conf_addr  = (sel >= 7) ? 3'd7 : 3'(sel);
            conf_data  = $urandom();
            if (conf_addr == 3'd0) conf_data[0] = ($urandom_range(0, 3) != 0);
            conf_tag          = 4'($urandom_range(0, 15));
            load_req_ready    = ($urandom_range(0, 3) != 0);
            atomic_resp_valid = ($urandom_range(0, 9) < 3);
            atomic_resp_tag   = 4'($urandom_range(0, 15));
            atomic_resp_data  = {$urandom(), $urandom()};
            applyStimulus();
        end
        conf_valid        = 1'b0;
        atomic_resp_valid = 1'b0;
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
